// File: rtl/raw2rgb_pkg.sv
// Shared types for the raw Bayer-to-RGB line sequencer.
// Holds the FSM state encoding, Bayer phase constants and phase helper.
package raw2rgb_pkg;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_RST_FIFO   = 3'd1,
      S_WAIT_RDY   = 3'd2,
      S_ARMED      = 3'd3,
      S_FIRST_LINE = 3'd4,
      S_STREAM     = 3'd5
   } state_t;

   // Bayer phase of a pixel: {row parity, col parity} relative to B.
   localparam logic [1:0] PH_B  = 2'b00;
   localparam logic [1:0] PH_GB = 2'b01;
   localparam logic [1:0] PH_GR = 2'b10;
   localparam logic [1:0] PH_R  = 2'b11;

   function automatic logic [1:0] bayer_phase(
      input logic [1:0] phase0,
      input logic       row_lsb,
      input logic       col_lsb
   );
      return phase0 ^ {row_lsb, col_lsb};
   endfunction

endpackage

// File: rtl/raw2rgb_edge_det.sv
// Registered edge detector: one flop of history, combinational pulse.
// Ports: clk, rst (sync, high), sig in; pulse out (rise, or fall if FALL=1).
module raw2rgb_edge_det #(
   parameter bit FALL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic pulse
);

   logic sig_d;

   always_ff @(posedge clk) begin
      if (rst) sig_d <= 1'b0;
      else     sig_d <= sig;
   end

   assign pulse = FALL ? (~sig & sig_d) : (sig & ~sig_d);

endmodule

// File: rtl/raw2rgb_line_ctrl.sv
// Line-buffer sequencer for the 2x2 Bayer-to-RGB stage.
// Ports: sync/valid/FIFO status in; FIFO rst/wr/rd, row/col, phase, err, state out.
module raw2rgb_line_ctrl
   import raw2rgb_pkg::*;
#(
   parameter int         IMG_W   = 1280,
   parameter int         RST_LEN = 8,
   parameter int         CNT_W   = 16,
   parameter logic [1:0] PHASE0  = PH_B
) (
   input  logic             I_Clk,
   input  logic             I_Rst,
   input  logic             I_V_Sync,
   input  logic             I_H_Sync,
   input  logic             I_Raw_Vaild,
   input  logic             I_Fifo_Full,
   input  logic             I_Fifo_Empty,
   input  logic             I_Fifo_Busy,
   output logic             O_Fifo_Rst,
   output logic             O_Fifo_Wr_En,
   output logic             O_Fifo_Rd_En,
   output logic [CNT_W-1:0] O_Row_Cnt,
   output logic [CNT_W-1:0] O_Col_Cnt,
   output logic [1:0]       O_Bayer_Phase,
   output logic             O_Pair_Vaild,
   output logic             O_Frame_Err,
   output logic [2:0]       O_State
);

   localparam int RC_W = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
   localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_LEN - 1);
   localparam logic [CNT_W-1:0] LINE_LEN = CNT_W'(IMG_W);
   localparam logic [CNT_W-1:0] ROW_MAX  = '1;

   state_t           state;
   logic [RC_W-1:0]  rst_cnt;
   logic [CNT_W-1:0] row_cnt;
   logic [CNT_W-1:0] col_cnt;
   logic             fifo_rst;
   logic             frame_err;

   logic vs_rise;
   logic eol;
   logic in_line;
   logic take;
   logic wr_en;
   logic rd_en;
   logic err_set;

   // Line sync only matters for upstream alignment.
   logic unused_hs;
   assign unused_hs = I_H_Sync;

   raw2rgb_edge_det #(.FALL(1'b0)) u_vs_det (
      .clk   (I_Clk),
      .rst   (I_Rst),
      .sig   (I_V_Sync),
      .pulse (vs_rise)
   );

   raw2rgb_edge_det #(.FALL(1'b1)) u_eol_det (
      .clk   (I_Clk),
      .rst   (I_Rst),
      .sig   (I_Raw_Vaild),
      .pulse (eol)
   );

   assign in_line = (state == S_FIRST_LINE) || (state == S_STREAM);

   // A frame restart in the same cycle drops the pixel.
   assign take  = I_Raw_Vaild & ~vs_rise & ~I_Rst;
   assign wr_en = take & (in_line || (state == S_ARMED));
   assign rd_en = take & (state == S_STREAM);

   assign err_set =
      (I_Raw_Vaild &&
       ((state == S_RST_FIFO) || (state == S_WAIT_RDY))) ||
      (eol && in_line && (col_cnt != LINE_LEN)) ||
      (wr_en && I_Fifo_Full) ||
      (rd_en && I_Fifo_Empty);

   always_ff @(posedge I_Clk) begin
      if (I_Rst) begin
         state     <= S_IDLE;
         rst_cnt   <= '0;
         row_cnt   <= '0;
         col_cnt   <= '0;
         fifo_rst  <= 1'b0;
         frame_err <= 1'b0;
      end else if (vs_rise) begin
         // Error history restarts here; a pixel colliding
         // with the restart is itself an error.
         state     <= S_RST_FIFO;
         rst_cnt   <= RST_LAST;
         row_cnt   <= '0;
         col_cnt   <= '0;
         fifo_rst  <= 1'b1;
         frame_err <= I_Raw_Vaild;
      end else begin
         if (err_set) frame_err <= 1'b1;
         unique case (state)
            S_IDLE: ;
            S_RST_FIFO: begin
               row_cnt <= '0;
               col_cnt <= '0;
               if (rst_cnt == '0) begin
                  fifo_rst <= 1'b0;
                  state    <= S_WAIT_RDY;
               end else begin
                  rst_cnt <= rst_cnt - 1'b1;
               end
            end
            S_WAIT_RDY: begin
               if (!I_Fifo_Busy) state <= S_ARMED;
            end
            S_ARMED: begin
               if (I_Raw_Vaild) begin
                  col_cnt <= col_cnt + 1'b1;
                  state   <= S_FIRST_LINE;
               end
            end
            S_FIRST_LINE, S_STREAM: begin
               if (I_Raw_Vaild) col_cnt <= col_cnt + 1'b1;
               if (eol) begin
                  col_cnt <= '0;
                  if (row_cnt != ROW_MAX)
                     row_cnt <= row_cnt + 1'b1;
                  if (state == S_FIRST_LINE)
                     state <= S_STREAM;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign O_Fifo_Rst    = fifo_rst;
   assign O_Fifo_Wr_En  = wr_en;
   assign O_Fifo_Rd_En  = rd_en;
   assign O_Pair_Vaild  = rd_en;
   assign O_Row_Cnt     = row_cnt;
   assign O_Col_Cnt     = col_cnt;
   assign O_Frame_Err   = frame_err;
   assign O_State       = state;
   assign O_Bayer_Phase = bayer_phase(PHASE0, row_cnt[0], col_cnt[0]);

endmodule

// File: tb/tb_raw2rgb_line_ctrl.sv
// Directed bench for raw2rgb_line_ctrl (IMG_W=8, RST_LEN=4, PHASE0=00).
// Walks reset, arming, streaming, phase, error and restart cases.
module tb_raw2rgb_line_ctrl;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        vs    = 1'b0;
   logic        hs    = 1'b0;
   logic        vaild = 1'b0;
   logic        full  = 1'b0;
   logic        empty = 1'b0;
   logic        busy  = 1'b0;
   logic        f_rst;
   logic        wr;
   logic        rd;
   logic [15:0] row;
   logic [15:0] col;
   logic [1:0]  phase;
   logic        pair;
   logic        err;
   logic [2:0]  st;

   int n_tot  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   raw2rgb_line_ctrl #(
      .IMG_W   (8),
      .RST_LEN (4),
      .CNT_W   (16),
      .PHASE0  (2'b00)
   ) dut (
      .I_Clk         (clk),
      .I_Rst         (rst),
      .I_V_Sync      (vs),
      .I_H_Sync      (hs),
      .I_Raw_Vaild   (vaild),
      .I_Fifo_Full   (full),
      .I_Fifo_Empty  (empty),
      .I_Fifo_Busy   (busy),
      .O_Fifo_Rst    (f_rst),
      .O_Fifo_Wr_En  (wr),
      .O_Fifo_Rd_En  (rd),
      .O_Row_Cnt     (row),
      .O_Col_Cnt     (col),
      .O_Bayer_Phase (phase),
      .O_Pair_Vaild  (pair),
      .O_Frame_Err   (err),
      .O_State       (st)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wait_armed;
      for (int k = 0; k < 20 && st != 3'd3; k++) tick;
      chk("reach_armed", {29'd0, st}, 32'd3);
   endtask

   task automatic send_line(input int n, input int r, input bit strm);
      for (int c = 0; c < n; c++) begin
         vaild = 1'b1;
         hs    = 1'b1;
         #1;
         chk("wr_en", {31'd0, wr}, 32'd1);
         chk("rd_en", {31'd0, rd}, {31'd0, strm});
         chk("pair", {31'd0, pair}, {31'd0, strm});
         chk("col", {16'd0, col}, c);
         chk("phase", {30'd0, phase}, {30'd0, r[0], c[0]});
         tick;
      end
      vaild = 1'b0;
      hs    = 1'b0;
      #1;
      chk("wr_gap", {31'd0, wr}, 32'd0);
      tick;
   endtask

   initial begin
      // reset state
      tick;
      tick;
      rst = 1'b0;
      #1;
      chk("rst_state", {29'd0, st}, 32'd0);
      chk("rst_frst", {31'd0, f_rst}, 32'd0);
      chk("rst_wr", {31'd0, wr}, 32'd0);
      chk("rst_rd", {31'd0, rd}, 32'd0);
      chk("rst_row", {16'd0, row}, 32'd0);
      chk("rst_col", {16'd0, col}, 32'd0);
      chk("rst_phase", {30'd0, phase}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);

      // frame start: FIFO reset for 4 cycles, busy for 3 more
      busy = 1'b1;
      vs   = 1'b1;
      tick;
      vs = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("fifo_rst_hi", {31'd0, f_rst}, 32'd1);
         chk("st_rst", {29'd0, st}, 32'd1);
         tick;
      end
      chk("fifo_rst_lo", {31'd0, f_rst}, 32'd0);
      chk("st_wait", {29'd0, st}, 32'd2);
      tick;
      chk("st_wait2", {29'd0, st}, 32'd2);
      tick;
      chk("st_wait3", {29'd0, st}, 32'd2);
      busy = 1'b0;
      tick;
      chk("st_armed", {29'd0, st}, 32'd3);

      // three full lines
      send_line(8, 0, 1'b0);
      chk("st_stream", {29'd0, st}, 32'd5);
      chk("row_1", {16'd0, row}, 32'd1);
      chk("col_clr", {16'd0, col}, 32'd0);
      send_line(8, 1, 1'b1);
      send_line(8, 2, 1'b1);
      chk("row_3", {16'd0, row}, 32'd3);
      chk("err_ok", {31'd0, err}, 32'd0);

      // short line flags a sticky error
      send_line(7, 3, 1'b1);
      chk("err_short", {31'd0, err}, 32'd1);
      tick;
      chk("err_sticky", {31'd0, err}, 32'd1);

      // next frame clears the error on entry
      vs = 1'b1;
      tick;
      vs = 1'b0;
      chk("st_rst2", {29'd0, st}, 32'd1);
      chk("err_clr", {31'd0, err}, 32'd0);
      chk("row_clr", {16'd0, row}, 32'd0);

      // pixel during FIFO reset is dropped and flagged
      vaild = 1'b1;
      #1;
      chk("wr_drop", {31'd0, wr}, 32'd0);
      tick;
      vaild = 1'b0;
      chk("err_drop", {31'd0, err}, 32'd1);
      wait_armed;
      chk("err_hold", {31'd0, err}, 32'd1);

      // fresh frame, then read while FIFO empty
      tick;
      vs = 1'b1;
      tick;
      vs = 1'b0;
      wait_armed;
      chk("err_clr2", {31'd0, err}, 32'd0);
      send_line(8, 0, 1'b0);
      chk("err_clean", {31'd0, err}, 32'd0);
      vaild = 1'b1;
      empty = 1'b1;
      #1;
      chk("rd_empty", {31'd0, rd}, 32'd1);
      tick;
      empty = 1'b0;
      chk("err_empty", {31'd0, err}, 32'd1);
      tick;

      // V_Sync mid-line in STREAM with a pixel present
      vs = 1'b1;
      #1;
      chk("wr_vs", {31'd0, wr}, 32'd0);
      chk("rd_vs", {31'd0, rd}, 32'd0);
      tick;
      vs    = 1'b0;
      vaild = 1'b0;
      chk("st_restart", {29'd0, st}, 32'd1);
      chk("row_restart", {16'd0, row}, 32'd0);
      chk("col_restart", {16'd0, col}, 32'd0);
      chk("err_vs_px", {31'd0, err}, 32'd1);
      chk("frst_restart", {31'd0, f_rst}, 32'd1);

      // I_Rst mid-frame
      wait_armed;
      vaild = 1'b1;
      tick;
      tick;
      tick;
      chk("col_mid", {16'd0, col}, 32'd3);
      rst = 1'b1;
      #1;
      chk("wr_in_rst", {31'd0, wr}, 32'd0);
      tick;
      rst = 1'b0;
      #1;
      chk("mrst_state", {29'd0, st}, 32'd0);
      chk("mrst_wr", {31'd0, wr}, 32'd0);
      chk("mrst_rd", {31'd0, rd}, 32'd0);
      chk("mrst_pair", {31'd0, pair}, 32'd0);
      chk("mrst_frst", {31'd0, f_rst}, 32'd0);
      chk("mrst_row", {16'd0, row}, 32'd0);
      chk("mrst_col", {16'd0, col}, 32'd0);
      chk("mrst_err", {31'd0, err}, 32'd0);
      chk("mrst_phase", {30'd0, phase}, 32'd0);
      tick;
      chk("idle_ignore", {29'd0, st}, 32'd0);
      chk("idle_col", {16'd0, col}, 32'd0);
      vaild = 1'b0;
      tick;

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
